// File: rtl/cpc_mem_arbiter.sv
// Shares one 16-bit-read RAM port between Gate Array video fetch, Z80 memory cycles and the ROM/disk loader.
// Video has strict priority; the CPU access is edge-captured into a single pending slot.
module cpc_mem_arbiter #(
  parameter int unsigned RD_LAT   = 3,
  parameter int unsigned RECOV    = 1,
  parameter logic [7:0]  VID_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [14:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_busy,
  input  logic        ld_wr,
  input  logic [22:0] ld_addr,
  input  logic [7:0]  ld_din,
  output logic        ld_ack,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [22:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic [15:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
  typedef enum logic [1:0] {SRC_VID, SRC_LD, SRC_CPU} src_t;

  localparam logic [2:0] LAT_LAST   = 3'(RD_LAT - 1);
  localparam logic [2:0] RECOV_LAST = 3'(RECOV - 1);

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cur_we_q, cur_we_d;
  logic        cpu_prev_q, cpu_prev_d;
  logic        cpu_busy_q, cpu_busy_d;
  logic        cpu_we_q, cpu_we_d;
  logic [22:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  cpu_din_q, cpu_din_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        vid_ack_q, vid_ack_d;
  logic [15:0] vid_data_q, vid_data_d;
  logic        ld_ack_q, ld_ack_d;

  logic cpu_req, vid_go, ld_go, done;

  // A request is not re-granted in the cycle its own ack is showing.
  assign cpu_req = cpu_rd | cpu_wr;
  assign vid_go  = vid_req & ~vid_ack_q;
  assign ld_go   = ld_wr & ~ld_ack_q;
  assign done    = cur_we_q ? (cnt_q == 3'd0) : (cnt_q == LAT_LAST);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    cur_we_d   = cur_we_q;
    cpu_prev_d = cpu_req;
    cpu_busy_d = cpu_busy_q;
    cpu_we_d   = cpu_we_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    cpu_dout_d = cpu_dout_q;
    vid_ack_d  = 1'b0;
    vid_data_d = vid_data_q;
    ld_ack_d   = 1'b0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;

    if (cpu_req && !cpu_prev_q && !cpu_busy_q) begin
      cpu_busy_d = 1'b1;
      cpu_we_d   = cpu_wr;
      cpu_addr_d = cpu_addr;
      cpu_din_d  = cpu_din;
    end

    case (state_q)
      S_IDLE: begin
        if (vid_go) begin
          ram_cs   = 1'b1;
          ram_addr = {VID_BASE, vid_addr};
          src_d    = SRC_VID;
          cur_we_d = 1'b0;
        end else if (ld_go) begin
          ram_cs   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = ld_addr;
          ram_din  = ld_din;
          src_d    = SRC_LD;
          cur_we_d = 1'b1;
        end else if (cpu_busy_q) begin
          ram_cs   = 1'b1;
          ram_we   = cpu_we_q;
          ram_addr = cpu_addr_q;
          ram_din  = cpu_din_q;
          src_d    = SRC_CPU;
          cur_we_d = cpu_we_q;
        end
        if (ram_cs) begin
          state_d = S_ACCESS;
          cnt_d   = 3'd0;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 3'd1;
        if (done) begin
          case (src_q)
            SRC_VID: begin
              vid_ack_d  = 1'b1;
              vid_data_d = ram_dout;
            end
            SRC_LD:  ld_ack_d = 1'b1;
            default: begin
              cpu_busy_d = 1'b0;
              if (!cur_we_q) cpu_dout_d = cpu_addr_q[0] ? ram_dout[15:8] : ram_dout[7:0];
            end
          endcase
          cnt_d   = 3'd0;
          state_d = (RECOV == 0) ? S_IDLE : S_RECOVER;
        end
      end
      S_RECOVER: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == RECOV_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= SRC_VID;
      cnt_q      <= '0;
      cur_we_q   <= 1'b0;
      cpu_prev_q <= 1'b0;
      cpu_busy_q <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_dout_q <= 8'hFF;
      vid_ack_q  <= 1'b0;
      vid_data_q <= '0;
      ld_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      cur_we_q   <= cur_we_d;
      cpu_prev_q <= cpu_prev_d;
      cpu_busy_q <= cpu_busy_d;
      cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      cpu_dout_q <= cpu_dout_d;
      vid_ack_q  <= vid_ack_d;
      vid_data_q <= vid_data_d;
      ld_ack_q   <= ld_ack_d;
    end
  end

  assign vid_ack  = vid_ack_q;
  assign vid_data = vid_data_q;
  assign ld_ack   = ld_ack_q;
  assign cpu_busy = cpu_busy_q;
  assign cpu_dout = cpu_dout_q;

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// Directed bench for cpc_mem_arbiter (RD_LAT=3, RECOV=1, VID_BASE=0) with a fixed-latency RAM model.
module tb_cpc_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [14:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_busy;
  logic        ld_wr = 1'b0;
  logic [22:0] ld_addr = '0;
  logic [7:0]  ld_din = '0;
  logic        ld_ack;
  logic        ram_cs, ram_we;
  logic [22:0] ram_addr;
  logic [7:0]  ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem_word = '0;
  logic [2:0]  cs_pipe = '0;
  int n_checks = 0;
  int n_fail = 0;

  cpc_mem_arbiter #(.RD_LAT(3), .RECOV(1), .VID_BASE(8'h00)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read data is valid only in the single cycle RD_LAT clocks after ram_cs.
  always @(posedge clk) cs_pipe <= {cs_pipe[1:0], ram_cs & ~ram_we};
  assign ram_dout = cs_pipe[2] ? mem_word : 16'hDEAD;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    step(2);
    n_checks++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", ram_cs); end
    n_checks++; if (vid_ack !== 1'b0 || ld_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got %b%b want 00", vid_ack, ld_ack); end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", cpu_busy); end
    n_checks++; if (vid_data !== 16'h0000) begin n_fail++; $display("FAIL reset_vid_data: got %h want 0000", vid_data); end
    n_checks++; if (cpu_dout !== 8'hFF) begin n_fail++; $display("FAIL reset_cpu_dout: got %h want ff", cpu_dout); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_video;
    mem_word = 16'hA55A;
    vid_addr = 15'h1234;
    vid_req  = 1'b1;
    #1;
    n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b0) begin n_fail++; $display("FAIL vid_cs: got cs=%b we=%b want cs=1 we=0", ram_cs, ram_we); end
    n_checks++; if (ram_addr !== 23'h001234) begin n_fail++; $display("FAIL vid_addr: got %h want 001234", ram_addr); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      if (k < 4) begin
        n_checks++; if (vid_ack !== 1'b0 || ram_cs !== 1'b0) begin n_fail++; $display("FAIL vid_early T%0d: got ack=%b cs=%b want 0 0", k, vid_ack, ram_cs); end
      end
    end
    n_checks++; if (vid_ack !== 1'b1) begin n_fail++; $display("FAIL vid_ack_T4: got %b want 1", vid_ack); end
    n_checks++; if (vid_data !== 16'hA55A) begin n_fail++; $display("FAIL vid_data: got %h want a55a", vid_data); end
    vid_req = 1'b0;
    step(1);
    n_checks++; if (vid_ack !== 1'b0 || vid_data !== 16'hA55A) begin n_fail++; $display("FAIL vid_hold: got ack=%b data=%h want 0 a55a", vid_ack, vid_data); end
  endtask

  task automatic test_cpu_read;
    int cs_seen;
    step(2);
    mem_word = 16'h3C12;
    cpu_addr = 23'h000101;
    cpu_rd   = 1'b1;
    step(1);
    n_checks++; if (ram_cs !== 1'b1 || ram_addr !== 23'h000101 || ram_we !== 1'b0) begin n_fail++; $display("FAIL cpurd_cs: got cs=%b addr=%h we=%b want 1 000101 0", ram_cs, ram_addr, ram_we); end
    for (int k = 0; k <= 3; k++) begin
      n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL cpurd_busy T%0d: got %b want 1", k, cpu_busy); end
      step(1);
    end
    n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL cpurd_busy_T4: got %b want 0", cpu_busy); end
    n_checks++; if (cpu_dout !== 8'h3C) begin n_fail++; $display("FAIL cpurd_dout: got %h want 3c", cpu_dout); end
    cs_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (ram_cs === 1'b1) cs_seen++;
      step(1);
    end
    n_checks++; if (cs_seen != 0) begin n_fail++; $display("FAIL cpurd_retrigger: got %0d cs want 0", cs_seen); end
    cpu_rd = 1'b0;
  endtask

  task automatic test_priority;
    step(2);
    mem_word = 16'hBEEF;
    vid_addr = 15'h0042;
    vid_req  = 1'b1;
    cpu_addr = 23'h000200;
    cpu_rd   = 1'b1;
    #1;
    n_checks++; if (ram_cs !== 1'b1 || ram_addr !== 23'h000042) begin n_fail++; $display("FAIL prio_vid_first: got cs=%b addr=%h want 1 000042", ram_cs, ram_addr); end
    step(1);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL prio_cpu_pending: got %b want 1", cpu_busy); end
    step(3);
    n_checks++; if (vid_ack !== 1'b1 || vid_data !== 16'hBEEF) begin n_fail++; $display("FAIL prio_vid_ack: got ack=%b data=%h want 1 beef", vid_ack, vid_data); end
    n_checks++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL prio_cs_at_ack: got %b want 0", ram_cs); end
    vid_req = 1'b0;
    step(1);
    n_checks++; if (ram_cs !== 1'b1 || ram_addr !== 23'h000200) begin n_fail++; $display("FAIL prio_cpu_cs: got cs=%b addr=%h want 1 000200", ram_cs, ram_addr); end
    step(4);
    n_checks++; if (cpu_busy !== 1'b0 || cpu_dout !== 8'hEF) begin n_fail++; $display("FAIL prio_cpu_done: got busy=%b dout=%h want 0 ef", cpu_busy, cpu_dout); end
    cpu_rd = 1'b0;
  endtask

  task automatic test_cpu_write;
    int cs_seen, acks;
    step(2);
    cpu_addr = 23'h004000;
    cpu_din  = 8'h7E;
    cpu_wr   = 1'b1;
    step(1);
    n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 23'h004000 || ram_din !== 8'h7E) begin
      n_fail++; $display("FAIL cpuwr_cmd: got cs=%b we=%b addr=%h din=%h want 1 1 004000 7e", ram_cs, ram_we, ram_addr, ram_din); end
    cs_seen = 0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (ram_cs === 1'b1) cs_seen++;
      if (vid_ack === 1'b1 || ld_ack === 1'b1) acks++;
      if (k == 2) begin
        n_checks++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL cpuwr_busy_T2: got %b want 0", cpu_busy); end
      end
      step(1);
    end
    n_checks++; if (cs_seen != 1 || acks != 0) begin n_fail++; $display("FAIL cpuwr_single: got cs=%0d acks=%0d want 1 0", cs_seen, acks); end
    cpu_wr = 1'b0;
  endtask

  task automatic test_busy_ignore;
    int cs_seen;
    step(2);
    cpu_addr = 23'h000010;
    cpu_din  = 8'h11;
    cpu_wr   = 1'b1;
    step(1);
    n_checks++; if (ram_cs !== 1'b1 || ram_addr !== 23'h000010) begin n_fail++; $display("FAIL ign_first: got cs=%b addr=%h want 1 000010", ram_cs, ram_addr); end
    cpu_wr = 1'b0;
    step(1);
    n_checks++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", cpu_busy); end
    cpu_addr = 23'h000020;
    cpu_din  = 8'h22;
    cpu_wr   = 1'b1;
    step(1);
    cs_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (ram_cs === 1'b1) cs_seen++;
      step(1);
    end
    n_checks++; if (cs_seen != 0 || cpu_busy !== 1'b0) begin n_fail++; $display("FAIL ign_second: got cs=%0d busy=%b want 0 0", cs_seen, cpu_busy); end
    cpu_wr = 1'b0;
  endtask

  task automatic test_loader;
    int cs_seen;
    step(2);
    ld_addr = 23'h000300;
    ld_din  = 8'h5A;
    ld_wr   = 1'b1;
    #1;
    n_checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 23'h000300 || ram_din !== 8'h5A) begin
      n_fail++; $display("FAIL ld_cmd: got cs=%b we=%b addr=%h din=%h want 1 1 000300 5a", ram_cs, ram_we, ram_addr, ram_din); end
    step(1);
    n_checks++; if (ld_ack !== 1'b0) begin n_fail++; $display("FAIL ld_ack_T1: got %b want 0", ld_ack); end
    step(1);
    n_checks++; if (ld_ack !== 1'b1) begin n_fail++; $display("FAIL ld_ack_T2: got %b want 1", ld_ack); end
    ld_wr = 1'b0;
    step(1);
    cs_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (ram_cs === 1'b1 || ld_ack === 1'b1) cs_seen++;
      step(1);
    end
    n_checks++; if (cs_seen != 0) begin n_fail++; $display("FAIL ld_once: got %0d extra events want 0", cs_seen); end
  endtask

  task automatic test_reset_mid;
    int events;
    step(2);
    mem_word = 16'h3C12;
    cpu_addr = 23'h000101;
    cpu_rd   = 1'b1;
    step(1);
    n_checks++; if (ram_cs !== 1'b1) begin n_fail++; $display("FAIL rst_mid_cs: got %b want 1", ram_cs); end
    step(2);
    reset  = 1'b1;
    cpu_rd = 1'b0;
    step(1);
    n_checks++; if (ram_cs !== 1'b0 || cpu_busy !== 1'b0 || cpu_dout !== 8'hFF) begin
      n_fail++; $display("FAIL rst_mid_state: got cs=%b busy=%b dout=%h want 0 0 ff", ram_cs, cpu_busy, cpu_dout); end
    reset = 1'b0;
    events = 0;
    for (int k = 0; k < 6; k++) begin
      if (ram_cs === 1'b1 || vid_ack === 1'b1 || ld_ack === 1'b1 || cpu_dout !== 8'hFF) events++;
      step(1);
    end
    n_checks++; if (events != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d events want 0", events); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_video;
    test_cpu_read;
    test_priority;
    test_cpu_write;
    test_busy_ignore;
    test_loader;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
